// File: rtl/conv_window_feeder_if.sv
// Handshake bundle between a raster pixel source, the 2x2 window feeder and
// the convolution neuron that consumes one packed window per transfer.
interface conv_window_feeder_if #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0]         in_pixel;
    logic                     in_valid;
    logic                     in_ready;
    logic [4*PIX_W-1:0]       win_pixels;
    logic                     win_valid;
    logic                     win_ready;
    logic [$clog2(IMG_H)-1:0] win_row;
    logic [$clog2(IMG_W)-1:0] win_col;
    logic                     frame_done;

    modport slave (
        input  in_pixel, in_valid, win_ready,
        output in_ready, win_pixels, win_valid, win_row, win_col, frame_done
    );

    modport master (
        output in_pixel, in_valid, win_ready,
        input  in_ready, win_pixels, win_valid, win_row, win_col, frame_done
    );
endinterface

// File: rtl/conv_window_feeder.sv
// Turns a raster pixel stream into every stride-1 2x2 window of the frame,
// using a one-row line buffer plus two pixel registers for the left column.
module conv_window_feeder #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    conv_window_feeder_if.slave  bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_PEN  = CW'(IMG_W - 2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_PEN  = RW'(IMG_H - 2);

    typedef enum logic {
        FIRST_ROW,
        BODY
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [PIX_W-1:0]   linebuf_q [IMG_W];
    logic [PIX_W-1:0]   prev_cur_q;
    logic [PIX_W-1:0]   prev_top_q;
    logic [4*PIX_W-1:0] win_pixels_q, win_pixels_d;
    logic [RW-1:0]      win_row_q, win_row_d;
    logic [CW-1:0]      win_col_q, win_col_d;
    logic               win_valid_q, win_valid_d;
    logic               frame_done_q, frame_done_d;

    logic               in_ready;
    logic               accept;
    logic               load;
    logic [PIX_W-1:0]   top_pix;

    // Input stalls only while a window is stuck at the output, no skid buffer.
    assign in_ready = !win_valid_q || bus.win_ready;
    assign accept   = bus.in_valid && in_ready;
    assign top_pix  = linebuf_q[col_q];
    assign load     = accept && (state_q == BODY) && (col_q != '0);

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        state_d      = state_q;
        win_pixels_d = win_pixels_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        win_valid_d  = win_valid_q;
        frame_done_d = win_valid_q && bus.win_ready &&
                       (win_row_q == ROW_PEN) && (win_col_q == COL_PEN);

        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d   = '0;
                    state_d = FIRST_ROW;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = BODY;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // A new window may replace the outgoing one on the same edge.
        if (load) begin
            win_pixels_d = {bus.in_pixel, prev_cur_q, top_pix, prev_top_q};
            win_row_d    = row_q - 1'b1;
            win_col_d    = col_q - 1'b1;
            win_valid_d  = 1'b1;
        end else if (bus.win_ready) begin
            win_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FIRST_ROW;
            col_q        <= '0;
            row_q        <= '0;
            win_pixels_q <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_pixels_q <= win_pixels_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pixel storage needs no reset; stale contents are overwritten by row 0.
    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf_q[col_q] <= bus.in_pixel;
            prev_cur_q       <= bus.in_pixel;
            prev_top_q       <= top_pix;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.win_pixels = win_pixels_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder: a 4x3 instance driven through a
// scoreboard built from an image model, plus a 2x2 instance for the minimum size.
module tb_conv_window_feeder;

    typedef struct {
        logic        inReady;
        logic        winValid;
        logic        frameDone;
        logic        accepted;
        logic        handshake;
        logic [31:0] pixels;
        logic [1:0]  row;
        logic [1:0]  col;
    } obs_t;

    typedef struct {
        logic [31:0] pixels;
        logic [1:0]  row;
        logic [1:0]  col;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    bit   expDone = 1'b0;
    logic [7:0] img [3][4];
    int   modelRow = 0;
    int   modelCol = 0;

    conv_window_feeder_if #(.IMG_W(4), .IMG_H(3), .PIX_W(8)) busA ();
    conv_window_feeder_if #(.IMG_W(2), .IMG_H(2), .PIX_W(8)) busB ();

    conv_window_feeder #(.IMG_W(4), .IMG_H(3), .PIX_W(8)) dutA (
        .clk   (clk),
        .rst_n (rstN),
        .bus   (busA)
    );

    conv_window_feeder #(.IMG_W(2), .IMG_H(2), .PIX_W(8)) dutB (
        .clk   (clk),
        .rst_n (rstN),
        .bus   (busB)
    );

    always #5 clk = ~clk;

    task automatic resetModel();
        sbq.delete();
        modelRow = 0;
        modelCol = 0;
        expDone  = 1'b0;
    endtask

    // One cycle on the 4x3 instance; accepted pixels feed the image model.
    task automatic driveCycle(input logic v, input logic [7:0] p, input logic wr, output obs_t o);
        exp_t e;
        @(negedge clk);
        busA.in_valid  = v;
        busA.in_pixel  = p;
        busA.win_ready = wr;
        #1;
        o.inReady   = busA.in_ready;
        o.winValid  = busA.win_valid;
        o.frameDone = busA.frame_done;
        o.pixels    = busA.win_pixels;
        o.row       = busA.win_row;
        o.col       = busA.win_col;
        o.accepted  = v && busA.in_ready;
        o.handshake = busA.win_valid && wr;
        if (o.accepted) begin
            img[modelRow][modelCol] = p;
            if (modelRow >= 1 && modelCol >= 1) begin
                e.pixels = {p, img[modelRow][modelCol-1], img[modelRow-1][modelCol],
                            img[modelRow-1][modelCol-1]};
                e.row  = 2'(modelRow - 1);
                e.col  = 2'(modelCol - 1);
                e.last = (modelRow == 2) && (modelCol == 3);
                sbq.push_back(e);
            end
            modelCol++;
            if (modelCol == 4) begin
                modelCol = 0;
                modelRow++;
                if (modelRow == 3) modelRow = 0;
            end
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        busA.in_valid = 1'b0; busA.in_pixel = '0; busA.win_ready = 1'b0;
        busB.in_valid = 1'b0; busB.in_pixel = '0; busB.win_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busA.win_valid !== 1'b0 || busA.frame_done !== 1'b0 || busA.in_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL reset_ctrlA: got v=%b fd=%b rdy=%b want 0 0 1",
                busA.win_valid, busA.frame_done, busA.in_ready); end
        checks++;
        if (busA.win_pixels !== 32'h0 || busA.win_row !== 2'd0 || busA.win_col !== 2'd0)
            begin errors++; $display("[TB] FAIL reset_dataA: got %h r=%0d c=%0d want 0 0 0",
                busA.win_pixels, busA.win_row, busA.win_col); end
        checks++;
        if (busB.win_valid !== 1'b0 || busB.frame_done !== 1'b0 || busB.win_pixels !== 32'h0)
            begin errors++; $display("[TB] FAIL reset_B: got v=%b fd=%b px=%h want 0 0 0",
                busB.win_valid, busB.frame_done, busB.win_pixels); end
        rstN = 1'b1;
        resetModel();
    endtask

    task automatic test_single_frame();
        logic [31:0] refw [6] = '{32'h05040100, 32'h06050201, 32'h07060302,
                                  32'h09080504, 32'h0A090605, 32'h0B0A0706};
        int sent = 0, cyc = 0, hs = 0, pulses = 0;
        obs_t o;
        exp_t e;
        $display("[TB] single frame 4x3");
        while ((sent < 12 || sbq.size() != 0 || expDone) && cyc < 200) begin
            driveCycle(sent < 12, 8'(sent), 1'b1, o);
            cyc++;
            if (o.accepted) sent++;
            checks++;
            if (o.frameDone !== expDone) begin errors++;
                $display("[TB] FAIL single_done: got %b want %b", o.frameDone, expDone); end
            if (o.frameDone) pulses++;
            expDone = 1'b0;
            if (o.handshake) begin
                checks++;
                if (sbq.size() == 0) begin errors++;
                    $display("[TB] FAIL single_extra: got window %h want none", o.pixels); end
                else begin
                    e = sbq.pop_front();
                    if ({o.row, o.col, o.pixels} !== {e.row, e.col, e.pixels}) begin errors++;
                        $display("[TB] FAIL single_win: got %h (%0d,%0d) want %h (%0d,%0d)",
                            o.pixels, o.row, o.col, e.pixels, e.row, e.col); end
                    if (hs < 6) begin
                        checks++;
                        if (o.pixels !== refw[hs]) begin errors++;
                            $display("[TB] FAIL single_ref: got %h want %h", o.pixels, refw[hs]); end
                    end
                    hs++;
                    if (e.last) expDone = 1'b1;
                end
            end
        end
        checks++;
        if (cyc >= 200) begin errors++; $display("[TB] FAIL single_timeout: got %0d cycles want <200", cyc); end
        checks++;
        if (hs != 6 || pulses != 1) begin errors++;
            $display("[TB] FAIL single_count: got %0d windows %0d pulses want 6 1", hs, pulses); end
    endtask

    task automatic test_stall();
        int sent = 0, cyc = 0, hs = 0, pulses = 0, stall = 0;
        obs_t o;
        exp_t e;
        $display("[TB] stall on second window");
        while ((sent < 12 || sbq.size() != 0 || expDone) && cyc < 200) begin
            driveCycle(sent < 12, 8'(sent), stall == 0, o);
            cyc++;
            if (o.accepted) sent++;
            if (stall > 0) begin
                checks++;
                if (o.inReady !== 1'b0 || o.winValid !== 1'b1 || o.pixels !== 32'h06050201) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got rdy=%b v=%b %h want 0 1 06050201",
                        o.inReady, o.winValid, o.pixels);
                end
                stall--;
            end
            checks++;
            if (o.frameDone !== expDone) begin errors++;
                $display("[TB] FAIL stall_done: got %b want %b", o.frameDone, expDone); end
            if (o.frameDone) pulses++;
            expDone = 1'b0;
            if (o.handshake) begin
                checks++;
                if (sbq.size() == 0) begin errors++;
                    $display("[TB] FAIL stall_extra: got window %h want none", o.pixels); end
                else begin
                    e = sbq.pop_front();
                    if ({o.row, o.col, o.pixels} !== {e.row, e.col, e.pixels}) begin errors++;
                        $display("[TB] FAIL stall_win: got %h (%0d,%0d) want %h (%0d,%0d)",
                            o.pixels, o.row, o.col, e.pixels, e.row, e.col); end
                    hs++;
                    if (hs == 1) stall = 3;
                    if (e.last) expDone = 1'b1;
                end
            end
        end
        checks++;
        if (cyc >= 200 || hs != 6 || pulses != 1) begin errors++;
            $display("[TB] FAIL stall_count: got %0d windows %0d pulses %0d cycles want 6 1 <200",
                hs, pulses, cyc); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, cyc = 0, hs = 0, pulses = 0;
        obs_t o;
        exp_t e;
        $display("[TB] two frames back to back");
        while ((sent < 24 || sbq.size() != 0 || expDone) && cyc < 300) begin
            driveCycle(sent < 24, (sent < 12) ? 8'(sent) : 8'(88 + sent), 1'b1, o);
            cyc++;
            if (o.accepted) sent++;
            checks++;
            if (o.frameDone !== expDone) begin errors++;
                $display("[TB] FAIL b2b_done: got %b want %b", o.frameDone, expDone); end
            if (o.frameDone) pulses++;
            expDone = 1'b0;
            if (o.handshake) begin
                checks++;
                if (sbq.size() == 0) begin errors++;
                    $display("[TB] FAIL b2b_extra: got window %h want none", o.pixels); end
                else begin
                    e = sbq.pop_front();
                    if ({o.row, o.col, o.pixels} !== {e.row, e.col, e.pixels}) begin errors++;
                        $display("[TB] FAIL b2b_win: got %h (%0d,%0d) want %h (%0d,%0d)",
                            o.pixels, o.row, o.col, e.pixels, e.row, e.col); end
                    if (hs == 6) begin
                        checks++;
                        if (o.pixels !== 32'h69686564) begin errors++;
                            $display("[TB] FAIL b2b_first2: got %h want 69686564", o.pixels); end
                    end
                    hs++;
                    if (e.last) expDone = 1'b1;
                end
            end
        end
        checks++;
        if (cyc >= 300 || hs != 12 || pulses != 2) begin errors++;
            $display("[TB] FAIL b2b_count: got %0d windows %0d pulses %0d cycles want 12 2 <300",
                hs, pulses, cyc); end
    endtask

    task automatic test_random();
        int sent = 0, cyc = 0, hs = 0, pulses = 0;
        logic v, wr;
        obs_t o;
        exp_t e;
        $display("[TB] random gaps and backpressure");
        while ((sent < 36 || sbq.size() != 0 || expDone) && cyc < 2000) begin
            v  = (sent < 36) && ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 3) != 0);
            driveCycle(v, 8'($urandom_range(0, 255)), wr, o);
            cyc++;
            if (o.accepted) sent++;
            checks++;
            if (o.inReady !== (!o.winValid || wr)) begin errors++;
                $display("[TB] FAIL rand_ready: got %b want %b", o.inReady, !o.winValid || wr); end
            if (o.frameDone !== expDone) begin errors++;
                $display("[TB] FAIL rand_done: got %b want %b", o.frameDone, expDone); end
            if (o.frameDone) pulses++;
            expDone = 1'b0;
            if (o.handshake) begin
                checks++;
                if (sbq.size() == 0) begin errors++;
                    $display("[TB] FAIL rand_extra: got window %h want none", o.pixels); end
                else begin
                    e = sbq.pop_front();
                    if ({o.row, o.col, o.pixels} !== {e.row, e.col, e.pixels}) begin errors++;
                        $display("[TB] FAIL rand_win: got %h (%0d,%0d) want %h (%0d,%0d)",
                            o.pixels, o.row, o.col, e.pixels, e.row, e.col); end
                    hs++;
                    if (e.last) expDone = 1'b1;
                end
            end
        end
        checks++;
        if (cyc >= 2000 || hs != 18 || pulses != 3) begin errors++;
            $display("[TB] FAIL rand_count: got %0d windows %0d pulses %0d cycles want 18 3 <2000",
                hs, pulses, cyc); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] refw [6] = '{32'h05040100, 32'h06050201, 32'h07060302,
                                  32'h09080504, 32'h0A090605, 32'h0B0A0706};
        int sent = 0, cyc = 0, hs = 0, pulses = 0;
        obs_t o;
        exp_t e;
        $display("[TB] reset in the middle of a frame");
        while (sent < 7 && cyc < 100) begin
            driveCycle(1'b1, 8'(sent), 1'b1, o);
            cyc++;
            if (o.accepted) sent++;
            if (o.handshake && sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++;
                if (o.pixels !== e.pixels) begin errors++;
                    $display("[TB] FAIL mid_win: got %h want %h", o.pixels, e.pixels); end
            end
        end
        @(negedge clk);
        rstN = 1'b0;
        busA.in_valid  = 1'b0;
        busA.win_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busA.win_valid !== 1'b0 || busA.frame_done !== 1'b0) begin errors++;
            $display("[TB] FAIL mid_drop: got v=%b fd=%b want 0 0", busA.win_valid, busA.frame_done); end
        rstN = 1'b1;
        resetModel();
        sent = 0;
        cyc  = 0;
        while ((sent < 12 || sbq.size() != 0 || expDone) && cyc < 200) begin
            driveCycle(sent < 12, 8'(sent), 1'b1, o);
            cyc++;
            if (o.accepted) sent++;
            checks++;
            if (o.frameDone !== expDone) begin errors++;
                $display("[TB] FAIL restart_done: got %b want %b", o.frameDone, expDone); end
            if (o.frameDone) pulses++;
            expDone = 1'b0;
            if (o.handshake) begin
                checks++;
                if (sbq.size() == 0 || hs >= 6) begin errors++;
                    $display("[TB] FAIL restart_extra: got window %h want none", o.pixels); end
                else begin
                    e = sbq.pop_front();
                    if ({o.row, o.col, o.pixels} !== {e.row, e.col, refw[hs]}) begin errors++;
                        $display("[TB] FAIL restart_win: got %h (%0d,%0d) want %h (%0d,%0d)",
                            o.pixels, o.row, o.col, refw[hs], e.row, e.col); end
                    hs++;
                    if (e.last) expDone = 1'b1;
                end
            end
        end
        checks++;
        if (cyc >= 200 || hs != 6 || pulses != 1) begin errors++;
            $display("[TB] FAIL restart_count: got %0d windows %0d pulses %0d cycles want 6 1 <200",
                hs, pulses, cyc); end
    endtask

    task automatic test_small_image();
        logic [7:0] px [4] = '{8'd7, 8'd8, 8'd9, 8'd10};
        int sent = 0, cyc = 0, hs = 0, pulses = 0;
        bit doneNext = 1'b0;
        logic hsNow;
        $display("[TB] minimum 2x2 image");
        busA.in_valid = 1'b0;
        while ((sent < 4 || hs < 1 || doneNext) && cyc < 50) begin
            @(negedge clk);
            busB.in_valid  = (sent < 4);
            busB.in_pixel  = px[sent % 4];
            busB.win_ready = 1'b1;
            #1;
            cyc++;
            hsNow = busB.win_valid;
            if (busB.in_valid && busB.in_ready) sent++;
            checks++;
            if (busB.frame_done !== doneNext) begin errors++;
                $display("[TB] FAIL small_done: got %b want %b", busB.frame_done, doneNext); end
            if (busB.frame_done) pulses++;
            doneNext = 1'b0;
            if (hsNow) begin
                checks++;
                if (busB.win_pixels !== 32'h0A090807 || busB.win_row !== 1'b0 || busB.win_col !== 1'b0)
                    begin errors++;
                    $display("[TB] FAIL small_win: got %h (%0d,%0d) want 0a090807 (0,0)",
                        busB.win_pixels, busB.win_row, busB.win_col); end
                hs++;
                doneNext = 1'b1;
            end
        end
        busB.in_valid = 1'b0;
        checks++;
        if (cyc >= 50 || hs != 1 || pulses != 1) begin errors++;
            $display("[TB] FAIL small_count: got %0d windows %0d pulses %0d cycles want 1 1 <50",
                hs, pulses, cyc); end
    endtask

    // Scenarios run back to back; the 4x3 instance is left at a frame boundary after each.
    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        test_small_image();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
